// File: rtl/ieee488_host_port.sv
// IEEE-488 controller byte engine: drives ATN/IFC, sources command/data bytes
// with the three-wire handshake, and accepts bytes as a listener when rx_en is set.
module ieee488_host_port #(
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 16000,
    parameter int IFC_LEN = 1600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_eoi,
    input  logic       tx_atn,
    input  logic       atn_release,
    input  logic       ifc_req,
    input  logic       rx_en,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_eoi,
    output logic       err_nodev,
    output logic       err_timeout,
    input  logic [7:0] ieee_data_i,
    input  logic       ieee_dav_i,
    input  logic       ieee_eoi_i,
    input  logic       ieee_nrfd_i,
    input  logic       ieee_ndac_i,
    input  logic       ieee_atn_i,
    output logic [7:0] ieee_data_o,
    output logic       ieee_dav_o,
    output logic       ieee_eoi_o,
    output logic       ieee_nrfd_o,
    output logic       ieee_ndac_o,
    output logic       ieee_atn_o,
    output logic       ieee_ifc_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int IFC_W = $clog2(IFC_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_WAIT_RFD, S_WAIT_DAC, S_DONE} src_state_t;
    typedef enum logic [1:0] {A_OFF, A_READY, A_ACCEPT, A_HOLD} acc_state_t;

    logic [12:0] sync1_q, sync2_q;
    logic [7:0]  data_s;
    logic        dav_s, eoi_s, nrfd_s, ndac_s, atn_s;

    src_state_t       src_state_q, src_state_d;
    logic [CNT_W-1:0] src_cnt_q, src_cnt_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_eoi_q, tx_eoi_d;
    logic             atn_q, atn_d, dav_q, dav_d, eoi_q, eoi_d, drive_q, drive_d;
    logic             src_nodev, src_to;

    acc_state_t       acc_state_q, acc_state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             rx_valid_q, rx_valid_d, rx_eoi_q, rx_eoi_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             nrfd_q, ndac_q, acc_to;

    logic             ifc_active_q, ifc_active_d;
    logic [IFC_W-1:0] ifc_cnt_q, ifc_cnt_d;
    logic             err_nodev_q, err_timeout_q;

    assign {data_s, dav_s, eoi_s, nrfd_s, ndac_s, atn_s} = sync2_q;

    always_comb begin
        ifc_active_d = ifc_active_q;
        ifc_cnt_d    = ifc_cnt_q;
        if (ifc_req) begin
            ifc_active_d = 1'b1;
            ifc_cnt_d    = '0;
        end else if (ifc_active_q && ce) begin
            if (ifc_cnt_q == IFC_W'(IFC_LEN - 1)) ifc_active_d = 1'b0;
            else                                  ifc_cnt_d    = ifc_cnt_q + IFC_W'(1);
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        src_state_d = src_state_q;
        src_cnt_d   = src_cnt_q;
        tx_byte_d   = tx_byte_q;
        tx_eoi_d    = tx_eoi_q;
        atn_d       = atn_q;
        dav_d       = dav_q;
        eoi_d       = eoi_q;
        drive_d     = drive_q;
        src_nodev   = 1'b0;
        src_to      = 1'b0;
        tx_ready    = 1'b0;
        unique case (src_state_q)
            S_IDLE: begin
                tx_ready = ~rx_en & ~ifc_active_q;
                if (tx_valid && tx_ready) begin
                    tx_byte_d   = tx_data;
                    tx_eoi_d    = tx_eoi;
                    atn_d       = tx_atn;
                    drive_d     = 1'b1;
                    src_cnt_d   = '0;
                    src_state_d = S_SETTLE;
                end else if (atn_release || (rx_en && acc_state_q == A_OFF)) begin
                    atn_d = 1'b0;
                end
            end
            S_SETTLE: if (ce) begin
                if (src_cnt_q == CNT_W'(SETTLE - 1)) begin
                    src_cnt_d   = '0;
                    src_state_d = S_WAIT_RFD;
                end else src_cnt_d = src_cnt_q + CNT_W'(1);
            end
            S_WAIT_RFD: begin
                if (nrfd_s && ndac_s) begin
                    src_nodev   = 1'b1;
                    drive_d     = 1'b0;
                    src_state_d = S_DONE;
                end else if (nrfd_s) begin
                    dav_d       = 1'b1;
                    eoi_d       = tx_eoi_q;
                    src_cnt_d   = '0;
                    src_state_d = S_WAIT_DAC;
                end else if (ce) begin
                    if (src_cnt_q == CNT_W'(TIMEOUT - 1)) src_to = 1'b1;
                    else src_cnt_d = src_cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_DAC: begin
                if (ndac_s) begin
                    dav_d       = 1'b0;
                    eoi_d       = 1'b0;
                    drive_d     = 1'b0;
                    src_state_d = S_DONE;
                end else if (ce) begin
                    if (src_cnt_q == CNT_W'(TIMEOUT - 1)) src_to = 1'b1;
                    else src_cnt_d = src_cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  src_state_d = S_IDLE;
            default: src_state_d = S_IDLE;
        endcase
        // An aborted handshake drops everything the source owns, ATN included.
        if (src_to) begin
            dav_d       = 1'b0;
            eoi_d       = 1'b0;
            drive_d     = 1'b0;
            atn_d       = 1'b0;
            src_state_d = S_DONE;
        end
        if (ifc_active_q) begin
            dav_d       = 1'b0;
            eoi_d       = 1'b0;
            drive_d     = 1'b0;
            atn_d       = 1'b0;
            src_state_d = S_IDLE;
        end
    end

    always_comb begin
        acc_state_d = acc_state_q;
        acc_cnt_d   = acc_cnt_q;
        rx_valid_d  = rx_valid_q & ~rx_ready;
        rx_data_d   = rx_data_q;
        rx_eoi_d    = rx_eoi_q;
        acc_to      = 1'b0;
        unique case (acc_state_q)
            A_OFF:   if (rx_en && src_state_q == S_IDLE) acc_state_d = A_HOLD;
            A_HOLD:  if (!rx_valid_q) acc_state_d = A_READY;
            // Bytes are only taken from a talker while our own ATN is off the bus.
            A_READY: if (!dav_s && atn_s) begin
                rx_data_d   = ~data_s;
                rx_eoi_d    = ~eoi_s;
                rx_valid_d  = 1'b1;
                acc_cnt_d   = '0;
                acc_state_d = A_ACCEPT;
            end
            A_ACCEPT: begin
                if (dav_s) acc_state_d = A_HOLD;
                else if (ce) begin
                    if (acc_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        acc_to      = 1'b1;
                        acc_state_d = A_HOLD;
                    end else acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end
            end
            default: acc_state_d = A_OFF;
        endcase
        if (!rx_en || ifc_active_q) acc_state_d = A_OFF;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            src_state_q   <= S_IDLE;
            src_cnt_q     <= '0;
            tx_byte_q     <= '0;
            tx_eoi_q      <= 1'b0;
            atn_q         <= 1'b0;
            dav_q         <= 1'b0;
            eoi_q         <= 1'b0;
            drive_q       <= 1'b0;
            acc_state_q   <= A_OFF;
            acc_cnt_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_eoi_q      <= 1'b0;
            nrfd_q        <= 1'b0;
            ndac_q        <= 1'b0;
            ifc_active_q  <= 1'b0;
            ifc_cnt_q     <= '0;
            err_nodev_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            sync1_q       <= {ieee_data_i, ieee_dav_i, ieee_eoi_i, ieee_nrfd_i, ieee_ndac_i, ieee_atn_i};
            sync2_q       <= sync1_q;
            src_state_q   <= src_state_d;
            src_cnt_q     <= src_cnt_d;
            tx_byte_q     <= tx_byte_d;
            tx_eoi_q      <= tx_eoi_d;
            atn_q         <= atn_d;
            dav_q         <= dav_d;
            eoi_q         <= eoi_d;
            drive_q       <= drive_d;
            acc_state_q   <= acc_state_d;
            acc_cnt_q     <= acc_cnt_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            rx_eoi_q      <= rx_eoi_d;
            nrfd_q        <= (acc_state_d == A_HOLD) || (acc_state_d == A_ACCEPT);
            ndac_q        <= (acc_state_d == A_HOLD) || (acc_state_d == A_READY);
            ifc_active_q  <= ifc_active_d;
            ifc_cnt_q     <= ifc_cnt_d;
            err_nodev_q   <= src_nodev;
            err_timeout_q <= src_to | acc_to;
        end
    end

    assign ieee_data_o = drive_q ? ~tx_byte_q : 8'hFF;
    assign ieee_dav_o  = ~dav_q;
    assign ieee_eoi_o  = ~eoi_q;
    assign ieee_atn_o  = ~atn_q;
    assign ieee_nrfd_o = ~nrfd_q;
    assign ieee_ndac_o = ~ndac_q;
    assign ieee_ifc_o  = ~ifc_active_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_eoi      = rx_eoi_q;
    assign err_nodev   = err_nodev_q;
    assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_ieee488_host_port.sv
// Bench for ieee488_host_port: a wire-ANDed bus with a model listener/talker,
// expected events queued by the stimulus and checked by an independent monitor.
module tb_ieee488_host_port;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 16000;
    localparam int IFC_LEN = 1600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0, ce = 1'b1;
    logic       tx_valid = 1'b0, tx_eoi = 1'b0, tx_atn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       atn_release = 1'b0, ifc_req = 1'b0, rx_en = 1'b0, rx_ready = 1'b0;
    logic       tx_ready, rx_valid, rx_eoi, err_nodev, err_timeout;
    logic [7:0] rx_data;
    logic [7:0] ieee_data_o;
    logic       ieee_dav_o, ieee_eoi_o, ieee_nrfd_o, ieee_ndac_o, ieee_atn_o, ieee_ifc_o;

    logic [7:0] dev_data = 8'hFF;
    logic       dev_dav = 1'b1, dev_eoi = 1'b1, dev_nrfd = 1'b1, dev_ndac = 1'b1;
    logic [7:0] bus_data;
    logic       bus_dav, bus_eoi, bus_nrfd, bus_ndac;
    int         lst_mode = 0;

    assign bus_data = ieee_data_o & dev_data;
    assign bus_dav  = ieee_dav_o & dev_dav;
    assign bus_eoi  = ieee_eoi_o & dev_eoi;
    assign bus_nrfd = ieee_nrfd_o & dev_nrfd;
    assign bus_ndac = ieee_ndac_o & dev_ndac;

    ieee488_host_port #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .IFC_LEN(IFC_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_eoi(tx_eoi), .tx_atn(tx_atn), .atn_release(atn_release),
        .ifc_req(ifc_req), .rx_en(rx_en), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_eoi(rx_eoi), .err_nodev(err_nodev), .err_timeout(err_timeout),
        .ieee_data_i(bus_data), .ieee_dav_i(bus_dav), .ieee_eoi_i(bus_eoi),
        .ieee_nrfd_i(bus_nrfd), .ieee_ndac_i(bus_ndac), .ieee_atn_i(ieee_atn_o),
        .ieee_data_o(ieee_data_o), .ieee_dav_o(ieee_dav_o), .ieee_eoi_o(ieee_eoi_o),
        .ieee_nrfd_o(ieee_nrfd_o), .ieee_ndac_o(ieee_ndac_o), .ieee_atn_o(ieee_atn_o),
        .ieee_ifc_o(ieee_ifc_o)
    );

    typedef enum logic [1:0] {EV_BUS, EV_RX, EV_NODEV, EV_TIMEOUT} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        logic       eoi;
        logic       atn;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] d, input logic e, input logic a);
        ev_t x;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none", int'(k));
        end else begin
            x = sb.pop_front();
            check("event_kind", 32'(int'(k)), 32'(int'(x.kind)));
            if (k == EV_BUS || k == EV_RX) begin
                check("event_data", 32'(d), 32'(x.data));
                check("event_eoi", 32'(e), 32'(x.eoi));
            end
            if (k == EV_BUS) check("event_atn", 32'(a), 32'(x.atn));
        end
    endtask

    // Monitor: decodes DUT activity into events and compares against the queue.
    logic mon_dav_q = 1'b1, mon_nodev_q = 1'b0, mon_to_q = 1'b0;
    initial forever begin
        @(negedge clk);
        if (mon_nodev_q) check("nodev_pulse_width", 32'(err_nodev), 32'd0);
        if (mon_to_q)    check("timeout_pulse_width", 32'(err_timeout), 32'd0);
        if (mon_dav_q && !ieee_dav_o) expect_ev(EV_BUS, ~ieee_data_o, ~ieee_eoi_o, ~ieee_atn_o);
        if (err_nodev && !mon_nodev_q) expect_ev(EV_NODEV, 8'h00, 1'b0, 1'b0);
        if (err_timeout && !mon_to_q)  expect_ev(EV_TIMEOUT, 8'h00, 1'b0, 1'b0);
        if (rx_valid && rx_ready)      expect_ev(EV_RX, rx_data, rx_eoi, 1'b0);
        mon_dav_q   = ieee_dav_o;
        mon_nodev_q = err_nodev;
        mon_to_q    = err_timeout;
    end

    // Model listener: 0 = absent, 1 = well-behaved, 2 = never releases NDAC.
    initial forever begin
        @(posedge clk);
        #2;
        case (lst_mode)
            1: if (!bus_dav) begin dev_nrfd = 1'b0; dev_ndac = 1'b1; end
               else          begin dev_nrfd = 1'b1; dev_ndac = 1'b0; end
            2: if (!bus_dav) begin dev_nrfd = 1'b0; dev_ndac = 1'b0; end
               else          begin dev_nrfd = 1'b1; dev_ndac = 1'b0; end
            default: begin dev_nrfd = 1'b1; dev_ndac = 1'b1; end
        endcase
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tx(input logic [7:0] d, input logic e, input logic a);
        int g = 0;
        tx_data  = d;
        tx_eoi   = e;
        tx_atn   = a;
        tx_valid = 1'b1;
        while (!tx_ready && g < 200) begin tick(1); g++; end
        check("tx_accept", 32'(tx_ready), 32'd1);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_dav(input logic lvl, input int budget, input string name, output int cyc);
        cyc = 0;
        while (ieee_dav_o !== lvl && cyc < budget) begin tick(1); cyc++; end
        check(name, 32'(ieee_dav_o), 32'(lvl));
    endtask

    task automatic wait_tx_ready(input string name);
        int g = 0;
        while (!tx_ready && g < 200) begin tick(1); g++; end
        check(name, 32'(tx_ready), 32'd1);
    endtask

    task automatic talk(input logic [7:0] d, input logic e);
        int g = 0;
        dev_data = ~d;
        dev_eoi  = ~e;
        while (!bus_nrfd && g < 200) begin tick(1); g++; end
        check("talk_rfd", 32'(bus_nrfd), 32'd1);
        tick(2);
        dev_dav = 1'b0;
        g = 0;
        while (!bus_ndac && g < 200) begin tick(1); g++; end
        check("talk_dac", 32'(bus_ndac), 32'd1);
        dev_dav  = 1'b1;
        dev_data = 8'hFF;
        dev_eoi  = 1'b1;
        tick(1);
    endtask

    int   cyc, c, c_low;
    logic ndac_seen, ready_seen;

    initial begin
        // Reset state
        tick(3);
        check("rst_data_o", 32'(ieee_data_o), 32'hFF);
        check("rst_dav_o", 32'(ieee_dav_o), 32'd1);
        check("rst_eoi_o", 32'(ieee_eoi_o), 32'd1);
        check("rst_nrfd_o", 32'(ieee_nrfd_o), 32'd1);
        check("rst_ndac_o", 32'(ieee_ndac_o), 32'd1);
        check("rst_atn_o", 32'(ieee_atn_o), 32'd1);
        check("rst_ifc_o", 32'(ieee_ifc_o), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_eoi", 32'(rx_eoi), 32'd0);
        check("rst_errs", 32'({err_nodev, err_timeout}), 32'd0);
        reset_n = 1'b1;
        lst_mode = 1;
        tick(4);

        // Command byte 0x28 under ATN
        sb.push_back('{kind: EV_BUS, data: 8'h28, eoi: 1'b0, atn: 1'b1});
        send_tx(8'h28, 1'b0, 1'b1);
        check("cmd_atn_low", 32'(ieee_atn_o), 32'd0);
        check("cmd_bus_data", 32'(ieee_data_o), 32'hD7);
        check("cmd_dav_idle", 32'(ieee_dav_o), 32'd1);
        wait_dav(1'b0, 100, "cmd_dav_assert", cyc);
        check("cmd_settle_min", 32'(cyc >= SETTLE), 32'd1);
        ndac_seen = 1'b0;
        c = 0;
        while (ieee_dav_o == 1'b0 && c < 100) begin
            if (bus_ndac) ndac_seen = 1'b1;
            tick(1);
            c++;
        end
        check("cmd_dav_release", 32'(ieee_dav_o), 32'd1);
        check("cmd_ndac_before_release", 32'(ndac_seen), 32'd1);
        check("cmd_data_release", 32'(ieee_data_o), 32'hFF);
        tick(3);
        check("cmd_atn_held", 32'(ieee_atn_o), 32'd0);
        check("cmd_tx_ready", 32'(tx_ready), 32'd1);

        // Data byte 0x41 with EOI, ATN released
        sb.push_back('{kind: EV_BUS, data: 8'h41, eoi: 1'b1, atn: 1'b0});
        send_tx(8'h41, 1'b1, 1'b0);
        check("data_atn_released", 32'(ieee_atn_o), 32'd1);
        wait_dav(1'b0, 100, "data_dav_assert", cyc);
        wait_dav(1'b1, 100, "data_dav_release", cyc);
        check("data_eoi_release", 32'(ieee_eoi_o), 32'd1);
        wait_tx_ready("data_tx_ready");

        // No device on the bus
        lst_mode = 0;
        tick(4);
        sb.push_back('{kind: EV_NODEV, data: 8'h00, eoi: 1'b0, atn: 1'b0});
        send_tx(8'h3F, 1'b0, 1'b0);
        wait_tx_ready("nodev_tx_ready");
        tick(2);
        check("nodev_dav_idle", 32'(ieee_dav_o), 32'd1);
        check("nodev_data_release", 32'(ieee_data_o), 32'hFF);

        // Listen: 0x55 held until rx_ready, then 0x0D with EOI
        sb.push_back('{kind: EV_RX, data: 8'h55, eoi: 1'b0, atn: 1'b0});
        sb.push_back('{kind: EV_RX, data: 8'h0D, eoi: 1'b1, atn: 1'b0});
        rx_ready = 1'b0;
        rx_en = 1'b1;
        tick(4);
        check("listen_tx_ready_low", 32'(tx_ready), 32'd0);
        talk(8'h55, 1'b0);
        tick(40);
        check("listen_nrfd_hold", 32'(ieee_nrfd_o), 32'd0);
        check("listen_valid_hold", 32'(rx_valid), 32'd1);
        check("listen_data1", 32'(rx_data), 32'h55);
        check("listen_eoi1", 32'(rx_eoi), 32'd0);
        rx_ready = 1'b1;
        talk(8'h0D, 1'b1);
        tick(6);
        check("listen_data2", 32'(rx_data), 32'h0D);
        check("listen_eoi2", 32'(rx_eoi), 32'd1);
        check("listen_valid_clear", 32'(rx_valid), 32'd0);
        rx_en = 1'b0;
        tick(2);
        check("listen_off_nrfd", 32'(ieee_nrfd_o), 32'd1);
        check("listen_off_ndac", 32'(ieee_ndac_o), 32'd1);
        rx_ready = 1'b0;

        // Handshake timeout: listener holds NDAC
        lst_mode = 2;
        tick(4);
        sb.push_back('{kind: EV_BUS, data: 8'h12, eoi: 1'b0, atn: 1'b0});
        sb.push_back('{kind: EV_TIMEOUT, data: 8'h00, eoi: 1'b0, atn: 1'b0});
        send_tx(8'h12, 1'b0, 1'b0);
        wait_dav(1'b0, 100, "to_dav_assert", cyc);
        c = 0;
        while (!err_timeout && c < TIMEOUT + 100) begin tick(1); c++; end
        check("to_ticks", 32'(c), 32'(TIMEOUT));
        check("to_dav_release", 32'(ieee_dav_o), 32'd1);
        check("to_data_release", 32'(ieee_data_o), 32'hFF);
        wait_tx_ready("to_tx_ready");

        // Asynchronous reset during S_WAIT_DAC, then IFC
        sb.push_back('{kind: EV_BUS, data: 8'h77, eoi: 1'b0, atn: 1'b1});
        send_tx(8'h77, 1'b0, 1'b1);
        wait_dav(1'b0, 100, "rstx_dav_assert", cyc);
        tick(5);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstx_dav", 32'(ieee_dav_o), 32'd1);
        check("rstx_data", 32'(ieee_data_o), 32'hFF);
        check("rstx_atn", 32'(ieee_atn_o), 32'd1);
        check("rstx_eoi", 32'(ieee_eoi_o), 32'd1);
        tick(2);
        reset_n = 1'b1;
        lst_mode = 0;
        tick(4);
        ifc_req = 1'b1;
        tick(1);
        ifc_req = 1'b0;
        c_low = 0;
        ready_seen = 1'b0;
        c = 0;
        while (c < IFC_LEN + 100) begin
            if (!ieee_ifc_o) begin
                c_low++;
                if (tx_ready) ready_seen = 1'b1;
            end else if (c_low > 0) begin
                break;
            end
            tick(1);
            c++;
        end
        check("ifc_len", 32'(c_low), 32'(IFC_LEN));
        check("ifc_tx_ready_low", 32'(ready_seen), 32'd0);
        check("ifc_released", 32'(ieee_ifc_o), 32'd1);
        tick(2);
        check("ifc_tx_ready_back", 32'(tx_ready), 32'd1);

        tick(5);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
